// File: rtl/alu_add_pipe_pkg.sv
// Shared types and sizing helpers for the pipelined carry-lookahead adder/subtractor.
package alu_add_pkg;
  typedef enum logic {OP_ADD, OP_SUB} op_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Bits resolved per pipeline stage; guarded so a bad STAGES reaches the config check.
  function automatic int seg_w(int width, int stages);
    return (stages < 1) ? width : width / stages;
  endfunction
endpackage

// File: rtl/alu_add_pipe_if.sv
// Operand-issue and result-writeback handshake bundle for alu_add_pipe.
interface alu_add_pipe_if import alu_add_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_cin;
  op_t                in_op;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_sum;
  logic               out_cout;
  logic               out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/alu_add_pipe_cla_segment.sv
// Combinational SEG_W-bit carry-lookahead segment with group propagate/generate.
module cla_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             group_p,
  output logic             group_g
);
  logic [SEG_W-1:0] p, g, pp, gg;
  logic [SEG_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Prefix P/G per bit so every carry is a two-level function of cin.
  always_comb begin
    pp    = '0;
    gg    = '0;
    c     = '0;
    pp[0] = p[0];
    gg[0] = g[0];
    for (int i = 1; i < SEG_W; i++) begin
      pp[i] = p[i] & pp[i-1];
      gg[i] = g[i] | (p[i] & gg[i-1]);
    end
    c[0] = cin;
    for (int i = 0; i < SEG_W; i++)
      c[i+1] = gg[i] | (pp[i] & cin);
  end

  assign sum     = p ^ c[SEG_W-1:0];
  assign cout    = c[SEG_W];
  assign group_p = pp[SEG_W-1];
  assign group_g = gg[SEG_W-1];
endmodule

// File: rtl/alu_add_pipe.sv
// WIDTH-bit adder/subtractor resolving one lookahead segment per stage, global-stall flow control.
module alu_add_pipe import alu_add_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_add_pipe_if.slave bus
);
  localparam int SEG_W = seg_w(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $fatal(1, "alu_add_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic [STAGES:0]          vld_pipe;
  logic                     stall;
  logic [WIDTH-1:0]         b_eff;
  logic [STAGES-1:0][1:0]   grp_pg_unused;  // group P/G kept for a future second lookahead level
  logic [WIDTH-1:0]         res_s;
  logic                     res_c, res_sub, res_am, res_bm;

  assign stall        = vld_pipe[STAGES] & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign b_eff        = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      vld_pipe <= '0;
    else if (!stall) vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
  end

  // Stage k holds the operand bits not yet added; they shrink by SEG_W each step.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int REM = WIDTH - k*SEG_W;
    logic [REM-1:0]   a_r, b_r, a_ld, b_ld;
    logic [WIDTH-1:0] s_r, s_ld, s_nxt;
    logic             sub_r, c_r, am_r, bm_r;
    logic             sub_ld, c_ld, am_ld, bm_ld;
    logic [SEG_W-1:0] sum;
    logic             cout;

    if (k == 0) begin : g_head
      assign a_ld   = bus.in_a;
      assign b_ld   = b_eff;
      assign sub_ld = (bus.in_op == OP_SUB);
      assign c_ld   = bus.in_cin ^ sub_ld;
      assign am_ld  = bus.in_a[WIDTH-1];
      assign bm_ld  = b_eff[WIDTH-1];
      assign s_ld   = '0;
    end else begin : g_tail
      assign a_ld   = g_stg[k-1].a_r[REM+SEG_W-1:SEG_W];
      assign b_ld   = g_stg[k-1].b_r[REM+SEG_W-1:SEG_W];
      assign sub_ld = g_stg[k-1].sub_r;
      assign c_ld   = g_stg[k-1].cout;
      assign am_ld  = g_stg[k-1].am_r;
      assign bm_ld  = g_stg[k-1].bm_r;
      assign s_ld   = g_stg[k-1].s_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_r <= '0; b_r <= '0; s_r <= '0;
        sub_r <= 1'b0; c_r <= 1'b0; am_r <= 1'b0; bm_r <= 1'b0;
      end else if (!stall) begin
        a_r <= a_ld; b_r <= b_ld; s_r <= s_ld;
        sub_r <= sub_ld; c_r <= c_ld; am_r <= am_ld; bm_r <= bm_ld;
      end
    end

    cla_segment #(.SEG_W(SEG_W)) u_cla (
      .a       (a_r[SEG_W-1:0]),
      .b       (b_r[SEG_W-1:0]),
      .cin     (c_r),
      .sum     (sum),
      .cout    (cout),
      .group_p (grp_pg_unused[k][1]),
      .group_g (grp_pg_unused[k][0])
    );

    assign s_nxt = s_r | (WIDTH'(sum) << (k*SEG_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_s <= '0; res_c <= 1'b0; res_sub <= 1'b0; res_am <= 1'b0; res_bm <= 1'b0;
    end else if (!stall) begin
      res_s   <= g_stg[STAGES-1].s_nxt;
      res_c   <= g_stg[STAGES-1].cout;
      res_sub <= g_stg[STAGES-1].sub_r;
      res_am  <= g_stg[STAGES-1].am_r;
      res_bm  <= g_stg[STAGES-1].bm_r;
    end
  end

  // A SUB without carry out is a borrow: sign-extend the difference with ones.
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_sum   = {(res_sub ? {WIDTH{~res_c}} : WIDTH'(res_c)), res_s};
  assign bus.out_cout  = res_c;
  assign bus.out_ovf   = (res_am == res_bm) && (res_s[WIDTH-1] != res_am);
endmodule
